zero_cross_meter_axis: RTL and testbench
========================================

Name: zero_cross_meter_axis

Overview:
- AXI-Stream sample consumer placed directly downstream of the continuous-wave generators used as test sources.
- Tracks signal sign with a hysteresis band and detects rising zero-crossings.
- At each rising crossing after the first, emits one record holding the cycle period (count of accepted samples) and the cycle peak-to-peak amplitude.
- Lets benches and the scope datapath check frequency and amplitude of the random-amplitude wave without a software post-pass.

Parameters:
- DW, 16: input sample width, signed.
- CW, 16: period counter width, unsigned, saturating.
- HYST, 256: hysteresis threshold, positive. Must satisfy 0 < HYST < 2^(DW-1).

Ports:
- aclk  in  1  clock.
- areset  in  1  reset, synchronous, active-high.
- tdata_s_i  in  DW  signed input sample.
- tvalid_s_i  in  1  input valid.
- tready_s_o  out  1  input ready.
- tdata_m_o  out  CW+DW+1  result record: [CW-1:0] = period, [CW+DW:CW] = unsigned peak-to-peak.
- tvalid_m_o  out  1  result valid.
- tready_m_i  in  1  downstream ready.

Behaviour:
- Interface decision: one clock, aclk. Reset is synchronous and active-high on areset.
- Reset values: tdata_m_o=0, tvalid_m_o=0, tready_s_o=0. Internally: state=INIT, period counter=0, max/min=0, armed=0.
- First cycle after reset: tready_s_o=1. It then stays 1 permanently; the block never backpressures its input.
- Beat: a sample is accepted when tvalid_s_i && tready_s_o. All state updates occur only on accepted beats; idle cycles change nothing.
- Sign FSM, evaluated on each accepted sample x:
  - INIT: x >= HYST -> POS; x <= -HYST -> NEG; otherwise stay.
  - POS: x <= -HYST -> NEG (falling crossing; no record).
  - NEG: x >= HYST -> POS (rising crossing).
- Samples strictly inside (-HYST, HYST) never change state.
- Cycle window: from the previous rising-crossing sample (inclusive) to the current rising-crossing sample (exclusive).
- Period: number of accepted beats in the window. The counter saturates at 2^CW-1 and does not wrap.
- Peak-to-peak: max - min over the window, computed in DW+1 bits, unsigned result.
- On each rising crossing:
  - Counter is reloaded to 1.
  - max and min are both reloaded to x.
  - If armed=0: set armed=1; no record.
  - If armed=1: load the record into the output register.
- Latency: tvalid_m_o rises on the clock edge following the accepting beat of the crossing sample, i.e. 1 cycle.
- Output handshake:
  - tdata_m_o is stable while tvalid_m_o && !tready_m_i.
  - tvalid_m_o clears on acceptance unless a new record loads in the same cycle, in which case tvalid_m_o stays 1 with the new data.
- Output full: if a new record is produced while the held record is not yet accepted, the new record is dropped and the held record is kept.
- Reset mid-operation: everything returns to reset values, a pending record is discarded, and the first crossing after reset only arms.

Optional Feature:
- Macro: ZCM_STATUS_EN.
- Defined: adds outputs overflow_o (1 bit, sticky, set when a record is dropped, cleared only by reset) and drop_cnt_o (16 bits, saturating count of dropped records). Both reset to 0.
- Undefined: these ports are absent, and dropped records are silent.

Decomposition:
- Shared package zcm_pkg holds:
  - FSM state enum: INIT, POS, NEG.
  - Record field offset/width localparams derived from DW and CW.
  - Default HYST constant.
- One sub-module, zcm_peak_tracker: running max/min with a reload input and the ptp subtract. Keeps the DW+1 arithmetic isolated and reusable by the scope trigger logic.

Test Plan (DW=16, CW=16, HYST=256 unless stated):
1. Continuous square wave (+1000 x5, -1000 x5) repeating, tready_m_i=1:
   - no record at the first rising crossing;
   - every following rising crossing gives period=10, ptp=2000, each one cycle after its crossing sample.
2. Samples alternating +100/-100 for 200 beats -> state stays INIT, tvalid_m_o never asserts.
3. Same square wave with 3 idle cycles between every beat -> records identical to test 1 (period=10).
4. tready_m_i=0 across two record generations -> first record held unchanged, second dropped. With ZCM_STATUS_EN: overflow_o=1, drop_cnt_o=1. Raising tready_m_i returns the first record.
5. CW=4, square wave with period 20 -> period field=15 (saturated), ptp=2000.
6. Assert areset for 1 cycle mid-cycle -> tvalid_m_o=0 next cycle. The next rising crossing only arms; the first record appears at the crossing after that.

Source files
------------

// File: rtl/zcm_pkg.sv
// Shared types and record layout helpers for the zero-crossing meter.
package zcm_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        POS  = 2'd1,
        NEG  = 2'd2
    } zcm_state_e;

    localparam int DW_DEF   = 16;
    localparam int CW_DEF   = 16;
    localparam int HYST_DEF = 256;

    // Record layout: period in the low CW bits, unsigned peak-to-peak above it.
    function automatic int rec_w(input int dw, input int cw);
        return cw + dw + 1;
    endfunction

    function automatic int ptp_lsb(input int cw);
        return cw;
    endfunction

    function automatic int ptp_w(input int dw);
        return dw + 1;
    endfunction

endpackage

// File: rtl/zcm_peak_tracker.sv
// Running max/min of signed samples with reload, and the DW+1 bit peak-to-peak.
module zcm_peak_tracker #(
    parameter int DW = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 reload_i,
    input  logic signed [DW-1:0] x_i,
    output logic        [DW:0]   ptp_o
);

    logic signed [DW-1:0] max_q, max_d;
    logic signed [DW-1:0] min_q, min_d;

    always_comb begin
        max_d = max_q;
        min_d = min_q;
        if (en_i) begin
            if (reload_i) begin
                max_d = x_i;
                min_d = x_i;
            end else begin
                if (x_i > max_q) max_d = x_i;
                if (x_i < min_q) min_d = x_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            max_q <= '0;
            min_q <= '0;
        end else begin
            max_q <= max_d;
            min_q <= min_d;
        end
    end

    // Sign-extend by one bit; max >= min so the modular difference is the true magnitude.
    assign ptp_o = {max_q[DW-1], max_q} - {min_q[DW-1], min_q};

endmodule

// File: rtl/zero_cross_meter_axis.sv
// AXI-Stream zero-crossing meter: period and peak-to-peak per rising crossing.
// Optional status outputs (overflow_o, drop_cnt_o) enabled by ZCM_STATUS_EN.
module zero_cross_meter_axis
    import zcm_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int CW   = CW_DEF,
    parameter int HYST = HYST_DEF
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic signed [DW-1:0]      tdata_s_i,
    input  logic                      tvalid_s_i,
    output logic                      tready_s_o,
    output logic [rec_w(DW,CW)-1:0]   tdata_m_o,
    output logic                      tvalid_m_o,
    input  logic                      tready_m_i
`ifdef ZCM_STATUS_EN
    ,
    output logic                      overflow_o,
    output logic [15:0]               drop_cnt_o
`endif
);

    localparam int RW = rec_w(DW, CW);
    localparam logic signed [DW-1:0] HYST_P = DW'(HYST);
    localparam logic signed [DW-1:0] HYST_N = -HYST_P;

    zcm_state_e          state_q, state_d;
    logic                rise;
    logic                ready_q;
    logic                armed_q, armed_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                tvalid_q, tvalid_d;
    logic [RW-1:0]       tdata_q, tdata_d;
    logic [ptp_w(DW)-1:0] ptp;
    logic                beat;
    logic                rec_vld;
    logic                load;

    assign beat = tvalid_s_i && ready_q;

    always_ff @(posedge aclk) begin
        if (areset) state_q <= INIT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        rise    = 1'b0;
        if (beat) begin
            case (state_q)
                INIT: begin
                    if (tdata_s_i >= HYST_P)      state_d = POS;
                    else if (tdata_s_i <= HYST_N) state_d = NEG;
                end
                POS: begin
                    if (tdata_s_i <= HYST_N) state_d = NEG;
                end
                NEG: begin
                    if (tdata_s_i >= HYST_P) begin
                        state_d = POS;
                        rise    = 1'b1;
                    end
                end
                default: state_d = INIT;
            endcase
        end
    end

    zcm_peak_tracker #(.DW(DW)) u_peak (
        .clk_i    (aclk),
        .rst_i    (areset),
        .en_i     (beat),
        .reload_i (rise),
        .x_i      (tdata_s_i),
        .ptp_o    (ptp)
    );

    // Record is built from the window state before this crossing sample updates it.
    assign rec_vld = rise && armed_q;
    assign load    = rec_vld && (!tvalid_q || tready_m_i);

    always_comb begin
        cnt_d    = cnt_q;
        armed_d  = armed_q;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        if (beat) begin
            if (rise) begin
                cnt_d   = CW'(1);
                armed_d = 1'b1;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (load) begin
            tvalid_d = 1'b1;
            tdata_d  = {ptp, cnt_q};
        end else if (tready_m_i) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            ready_q  <= 1'b0;
            armed_q  <= 1'b0;
            cnt_q    <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
        end else begin
            ready_q  <= 1'b1;
            armed_q  <= armed_d;
            cnt_q    <= cnt_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
        end
    end

    assign tready_s_o = ready_q;
    assign tvalid_m_o = tvalid_q;
    assign tdata_m_o  = tdata_q;

`ifdef ZCM_STATUS_EN
    logic        drop;
    logic        overflow_q;
    logic [15:0] drop_cnt_q;

    assign drop = rec_vld && !load;

    always_ff @(posedge aclk) begin
        if (areset) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_zero_cross_meter_axis.sv
// Directed bench for zero_cross_meter_axis with a reference model feeding record scoreboards.
module tb_zero_cross_meter_axis;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               areset;
    logic signed [15:0] tdata_s;
    logic               tvalid_s;
    logic               tready_s, tready_s4;
    logic [32:0]        tdata_m;
    logic               tvalid_m;
    logic               tready_m;
    logic [20:0]        tdata_m4;
    logic               tvalid_m4;
    logic               tready_m4;
`ifdef ZCM_STATUS_EN
    logic               overflow, overflow4;
    logic [15:0]        drop_cnt, drop_cnt4;
`endif

    zero_cross_meter_axis #(.DW(16), .CW(16), .HYST(256)) dut (
        .aclk       (clk),
        .areset     (areset),
        .tdata_s_i  (tdata_s),
        .tvalid_s_i (tvalid_s),
        .tready_s_o (tready_s),
        .tdata_m_o  (tdata_m),
        .tvalid_m_o (tvalid_m),
        .tready_m_i (tready_m)
`ifdef ZCM_STATUS_EN
        ,
        .overflow_o (overflow),
        .drop_cnt_o (drop_cnt)
`endif
    );

    zero_cross_meter_axis #(.DW(16), .CW(4), .HYST(256)) dut4 (
        .aclk       (clk),
        .areset     (areset),
        .tdata_s_i  (tdata_s),
        .tvalid_s_i (tvalid_s),
        .tready_s_o (tready_s4),
        .tdata_m_o  (tdata_m4),
        .tvalid_m_o (tvalid_m4),
        .tready_m_i (tready_m4)
`ifdef ZCM_STATUS_EN
        ,
        .overflow_o (overflow4),
        .drop_cnt_o (drop_cnt4)
`endif
    );

    int checks = 0;
    int errors = 0;
    logic [32:0] q16[$];
    logic [20:0] q4[$];
    int vld_seen = 0;
    int pop16 = 0;
    int pop4 = 0;

    // Reference model state
    int m_state;
    int m_max, m_min, m_cnt16, m_cnt4;
    bit m_armed;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_max = 0; m_min = 0; m_cnt16 = 0; m_cnt4 = 0; m_armed = 0;
        q16.delete();
        q4.delete();
    endtask

    task automatic model_beat(input int x);
        bit crossing;
        crossing = 0;
        case (m_state)
            0: if (x >= 256) m_state = 1; else if (x <= -256) m_state = 2;
            1: if (x <= -256) m_state = 2;
            default: if (x >= 256) begin m_state = 1; crossing = 1; end
        endcase
        if (crossing) begin
            if (m_armed) begin
                q16.push_back({17'(m_max - m_min), 16'(m_cnt16)});
                q4.push_back({17'(m_max - m_min), 4'(m_cnt4)});
            end
            m_armed = 1; m_cnt16 = 1; m_cnt4 = 1; m_max = x; m_min = x;
        end else begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt4 < 15) m_cnt4++;
            if (x > m_max) m_max = x;
            if (x < m_min) m_min = x;
        end
    endtask

    task automatic send(input int x, input int idle);
        tdata_s  = 16'(x);
        tvalid_s = 1'b1;
        model_beat(x);
        @(posedge clk); #1;
        tvalid_s = 1'b0;
        repeat (idle) begin @(posedge clk); #1; end
    endtask

    task automatic square(input int cycles, input int half, input int idle, input bit lat);
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < half; i++) begin
                send(1000, idle);
                if (lat && i == 0 && c >= 2) begin
                    chk("t1_latency_valid", 64'(tvalid_m), 64'd1);
                    chk("t1_record_const", 64'(tdata_m), {31'd0, 17'd2000, 16'd10});
                end
            end
            for (int i = 0; i < half; i++) send(-1000, idle);
        end
    endtask

    task automatic do_reset();
        areset   = 1'b1;
        tvalid_s = 1'b0;
        @(posedge clk); #1;
        chk("rst_tvalid", 64'(tvalid_m), 64'd0);
        chk("rst_tready_s", 64'(tready_s), 64'd0);
        chk("rst_tdata", 64'(tdata_m), 64'd0);
`ifdef ZCM_STATUS_EN
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
`endif
        areset = 1'b0;
        model_reset();
        @(posedge clk); #1;
        chk("rst_tready_s_up", 64'(tready_s), 64'd1);
    endtask

    always @(negedge clk) begin
        if (tvalid_m) vld_seen++;
        if (tvalid_m && tready_m) begin
            if (q16.size() == 0) chk("rec16_unexpected", 64'(q16.size()), 64'd1);
            else begin
                pop16++;
                chk("rec16", 64'(tdata_m), 64'(q16.pop_front()));
            end
        end
        if (tvalid_m4 && tready_m4) begin
            if (q4.size() == 0) chk("rec4_unexpected", 64'(q4.size()), 64'd1);
            else begin
                pop4++;
                chk("rec4", 64'(tdata_m4), 64'(q4.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        areset    = 1'b1;
        tdata_s   = '0;
        tvalid_s  = 1'b0;
        tready_m  = 1'b1;
        tready_m4 = 1'b1;
        model_reset();
        @(posedge clk); #1;
        do_reset();

        // Test 1: square wave, continuous, always ready
        pop16 = 0;
        square(6, 5, 0, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        chk("t1_count", 64'(pop16), 64'd4);
        chk("t1_drain", 64'(q16.size()), 64'd0);

        // Test 2: in-band alternation never leaves INIT
        do_reset();
        vld_seen = 0;
        for (int i = 0; i < 200; i++) send((i % 2 == 0) ? 100 : -100, 0);
        repeat (2) begin @(posedge clk); #1; end
        chk("t2_no_valid", 64'(vld_seen), 64'd0);

        // Test 3: idle gaps between beats
        do_reset();
        pop16 = 0;
        square(6, 5, 3, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        chk("t3_count", 64'(pop16), 64'd4);
        chk("t3_drain", 64'(q16.size()), 64'd0);

        // Test 4: backpressure holds first record, drops second
        do_reset();
        square(3, 5, 0, 1'b0);
        tready_m = 1'b0;
        square(1, 5, 0, 1'b0);
        chk("t4_held_valid", 64'(tvalid_m), 64'd1);
        chk("t4_held_data", 64'(tdata_m), {31'd0, 17'd2000, 16'd10});
        square(1, 5, 0, 1'b0);
        void'(q16.pop_back());
        chk("t4_still_held", 64'(tdata_m), {31'd0, 17'd2000, 16'd10});
        chk("t4_still_valid", 64'(tvalid_m), 64'd1);
`ifdef ZCM_STATUS_EN
        chk("t4_overflow", 64'(overflow), 64'd1);
        chk("t4_drop_cnt", 64'(drop_cnt), 64'd1);
`endif
        pop16 = 0;
        tready_m = 1'b1;
        @(posedge clk); #1;
        chk("t4_released", 64'(pop16), 64'd1);
        chk("t4_valid_clear", 64'(tvalid_m), 64'd0);
        chk("t4_drain", 64'(q16.size()), 64'd0);

        // Test 5: period 20 saturates the 4-bit counter
        do_reset();
        pop4 = 0;
        square(2, 10, 0, 1'b0);
        send(1000, 0);
        chk("t5_valid4", 64'(tvalid_m4), 64'd1);
        chk("t5_sat_rec4", 64'(tdata_m4), {43'd0, 17'd2000, 4'd15});
        chk("t5_rec16", 64'(tdata_m), {31'd0, 17'd2000, 16'd20});
        for (int i = 0; i < 9; i++) send(1000, 0);
        for (int i = 0; i < 10; i++) send(-1000, 0);
        send(1000, 0);
        repeat (3) begin @(posedge clk); #1; end
        chk("t5_count4", 64'(pop4), 64'd2);
        chk("t5_drain4", 64'(q4.size()), 64'd0);

        // Test 6: reset mid-cycle discards pending record and disarms
        do_reset();
        square(3, 5, 0, 1'b0);
        tready_m = 1'b0;
        send(1000, 0);
        chk("t6_pending", 64'(tvalid_m), 64'd1);
        send(1000, 0);
        send(1000, 0);
        do_reset();
        tready_m = 1'b1;
        pop16 = 0;
        square(1, 5, 0, 1'b0);
        send(1000, 0);
        chk("t6_arm_only", 64'(tvalid_m), 64'd0);
        for (int i = 0; i < 4; i++) send(1000, 0);
        for (int i = 0; i < 5; i++) send(-1000, 0);
        send(1000, 0);
        chk("t6_first_rec", 64'(tvalid_m), 64'd1);
        repeat (3) begin @(posedge clk); #1; end
        chk("t6_count", 64'(pop16), 64'd1);
        chk("t6_drain", 64'(q16.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
